hc4053_scan_ctrl: RTL
=====================

// Module: hc4053_scan_ctrl
// PURPOSE
//  Sequencer for the 74HC4053 triple 2:1 analog switch. Steps the 3-bit select code S
//  through a masked set of codes with break-before-make on active-low enable E, waits a
//  settle time, then hands off to the sampler through a req/ack handshake. Sits between
//  the calibration control logic and the 4053 (E, S pins).
// PARAMETERS
//  BBM_CYCLES      2    cycles with E=1 after S changes (break-before-make), >=1
//  SETTLE_CYCLES   8    cycles with E=0 before sample request, >=1
//  TIMEOUT_CYCLES  255  max SAMPLE wait for sample_ack (only with HC4053_SCAN_TIMEOUT_EN)
//  CNT_W           8    width of shared delay counter; must hold all three values above
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  start        in   1  begin a scan (pulse; ignored while busy)
//  stop         in   1  abort scan
//  continuous   in   1  1: wrap to lowest enabled code after the last one; latched at start
//  mask         in   8  bit k=1 -> visit code S=k; latched at start
//  E            out  1  4053 enable, active-low
//  S            out  3  4053 select code
//  sample_req   out  1  sample request to sampler
//  sample_ack   in   1  sampler done with current code
//  busy         out  1  1 whenever state != IDLE
//  done         out  1  one-cycle pulse: non-continuous scan completed
//  timeout_err  out  1  one-cycle pulse: sample_ack timeout (0 without macro)
// BEHAVIOUR
//  - All outputs registered. Reset: E=1, S=3'b000, sample_req=0, busy=0, done=0,
//    timeout_err=0, state=IDLE, counter=0. Reset wins over every other input.
//  - States: IDLE, BREAK, SETTLE, SAMPLE, NEXT.
//  - IDLE: E=1, S holds last value. start=1 && mask!=0 && stop=0 -> latch mask and
//    continuous, S <= lowest set bit index of mask, go BREAK. start with mask==0: ignored.
//  - BREAK: E=1 for exactly BBM_CYCLES cycles, then SETTLE.
//  - SETTLE: E=0 for exactly SETTLE_CYCLES cycles, then SAMPLE.
//  - SAMPLE: E=0, sample_req=1 until the cycle sample_ack=1 is sampled; that edge clears
//    sample_req and goes NEXT. sample_ack outside SAMPLE is ignored.
//  - NEXT (1 cycle, E=0): next set bit above S in latched mask exists -> S <= it, E <= 1,
//    BREAK. None: continuous=1 -> S <= lowest set bit, E <= 1, BREAK (single-bit mask
//    re-runs same code incl. BBM); continuous=0 -> E <= 1, done=1 for one cycle, IDLE.
//  - Latency: start edge -> sample_req high after 1+BBM_CYCLES+SETTLE_CYCLES cycles.
//  - Code change always occurs with E=1; E never low in the cycle S changes.
//  - stop=1 in any non-IDLE state: next cycle IDLE, E=1, sample_req=0, no done pulse,
//    S keeps value. start and stop same cycle: stop wins. start while busy: ignored.
//  - Mid-scan mask/continuous changes have no effect until next start.
// CONFIGURATION
//  HC4053_SCAN_TIMEOUT_EN defined: SAMPLE counts cycles; if TIMEOUT_CYCLES elapse without
//   ack -> sample_req=0, timeout_err=1 one cycle, proceed as NEXT (scan continues).
//   Ack on the same edge as expiry counts as ack, no error.
//  Not defined: SAMPLE waits indefinitely; timeout_err tied 0; no timeout counter logic.
// TESTING
//  1 rst=1 two cycles -> E=1, S=0, busy=0, sample_req=0, done=0.
//  2 mask=8'b1010_0100, continuous=0, ack 3 cycles after each req -> S visits 2,5,7;
//    req 11 cycles after start; E=1 whenever S changes; done pulse once; busy drops.
//  3 mask=8'h81, continuous=1, immediate ack -> S 0,7,0,7...; stop during SETTLE of
//    second 0 -> IDLE next cycle, E=1, no done, sample_req never rises.
//  4 start with mask=0 -> stays IDLE, busy=0; start+stop same cycle -> stays IDLE.
//  5 start pulses mid-scan and ack pulses while not in SAMPLE -> no effect on sequence.
//  6 (macro on, TIMEOUT_CYCLES=4) mask=8'h03, never ack -> each code: req high 4
//    cycles, timeout_err pulse, scan finishes with done; macro off -> req stays high.

Source files
------------

// File: rtl/hc4053_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hc4053_scan_ctrl
//
// Scan sequencer for a 74HC4053 triple 2:1 analog switch. Walks the 3-bit
// select code S through the codes enabled in a mask. Each code change is
// break-before-make: E (active-low) is held high for BBM_CYCLES and then
// released for SETTLE_CYCLES. After that the sampler is asked for a
// conversion through a sample_req/sample_ack handshake.
//
// Optional feature macro: HC4053_SCAN_TIMEOUT_EN
//   When it is defined, SAMPLE gives up after TIMEOUT_CYCLES without
//   sample_ack. It then pulses timeout_err and moves on to the next code.
//   When it is undefined, SAMPLE waits for sample_ack forever and
//   timeout_err is tied to 0.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   begin a scan (pulse, ignored while busy)
//   stop         in   abort the scan; wins over start
//   continuous   in   wrap to the lowest enabled code after the last one
//                     (latched at start)
//   mask[7:0]    in   bit k set -> visit code k (latched at start)
//   E            out  4053 enable, active-low
//   S[2:0]       out  4053 select code
//   sample_req   out  request to the sampler
//   sample_ack   in   sampler finished with the current code
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle pulse when a non-continuous scan completes
//   timeout_err  out  one-cycle pulse when sample_ack times out
// ---------------------------------------------------------------------------
module hc4053_scan_ctrl #(
    parameter int BBM_CYCLES     = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    input  logic [7:0] mask,
    output logic       E,
    output logic [2:0] S,
    output logic       sample_req,
    input  logic       sample_ack,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    // The shared delay counter must be able to hold every delay value.
    generate
        if (BBM_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
            BBM_CYCLES >= (2 ** CNT_W) || SETTLE_CYCLES >= (2 ** CNT_W) ||
            TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
            $error("hc4053_scan_ctrl: delay parameters out of range for CNT_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT
    } state_t;

    // The counter runs from 0 up to N-1, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] BBM_LAST    = CNT_W'(BBM_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef HC4053_SCAN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TOUT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         mask_q, mask_d;
    logic               cont_q, cont_d;
    logic               e_q, e_d;
    logic [2:0]         s_q, s_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tout_q, tout_d;
    logic [3:0]         nxt;

    // Index of the lowest set bit. The caller guarantees the mask is nonzero.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] res;
        res = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) res = 3'(k);
        end
        return res;
    endfunction

    // {found, code}: the lowest set bit of m strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) res = {1'b1, 3'(k)};
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        e_d     = e_q;
        s_d     = s_q;
        req_d   = req_q;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        nxt     = next_above(mask_q, s_q);

        case (state_q)
            ST_IDLE: begin
                e_d   = 1'b1;
                req_d = 1'b0;
                if (start && (mask != 8'd0) && !stop) begin
                    mask_d  = mask;
                    cont_d  = continuous;
                    s_d     = lowest_set(mask);
                    cnt_d   = '0;
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                e_d = 1'b1;
                if (cnt_q == BBM_LAST) begin
                    cnt_d   = '0;
                    e_d     = 1'b0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                e_d = 1'b0;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                e_d   = 1'b0;
                req_d = 1'b1;
                // An ack arriving on the expiry edge still counts as an ack.
                if (sample_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_NEXT;
                end
`ifdef HC4053_SCAN_TIMEOUT_EN
                else if (cnt_q == TOUT_LAST) begin
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_NEXT: begin
                // E rises on the same edge that S moves, so S never changes
                // while E is low.
                e_d   = 1'b1;
                cnt_d = '0;
                if (nxt[3]) begin
                    s_d     = nxt[2:0];
                    state_d = ST_BREAK;
                end else if (cont_q) begin
                    s_d     = lowest_set(mask_q);
                    state_d = ST_BREAK;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                e_d     = 1'b1;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // An abort overrides whatever the active state decided. S is kept.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            e_d     = 1'b1;
            s_d     = s_q;
            req_d   = 1'b0;
            done_d  = 1'b0;
            tout_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= 8'd0;
            cont_q  <= 1'b0;
            e_q     <= 1'b1;
            s_q     <= 3'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            e_q     <= e_d;
            s_q     <= s_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    assign E          = e_q;
    assign S          = s_q;
    assign sample_req = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef HC4053_SCAN_TIMEOUT_EN
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
